// File: rtl/io_sys_update_p.sv
// io_sys_update_p: IO-mapped front end for the remote system update (RSU) block.
// Define RSU_WDT_KICK_EN to build the free-running watchdog kick counter.
module io_sys_update_p #(
  parameter logic [15:0] CAddrBase = 16'h0000,
  parameter int unsigned CDataW    = 32,
  parameter int unsigned CBootCnt  = 2,
  parameter int unsigned CTimeout  = 1024,
  parameter int unsigned CWdtBit   = 7
) (
  input  logic              AClkH,
  input  logic              AResetH,
  input  logic              AClkHEn,
  input  logic [15:0]       AIoAddr,
  input  logic [63:0]       AIoMosi,
  output logic [63:0]       AIoMiso,
  input  logic [3:0]        AIoWrSize,
  input  logic [3:0]        AIoRdSize,
  output logic              AIoAddrAck,
  output logic              AIoAddrErr,
  output logic              AIoBusy,
  output logic [2:0]        ARsuParam,
  output logic [1:0]        ARsuSrc,
  output logic              ARsuReadParam,
  output logic              ARsuWriteParam,
  output logic [CDataW-1:0] ARsuDataIn,
  input  logic [CDataW-1:0] ARsuDataOut,
  input  logic              ARsuBusy,
  output logic              ARsuReconfig,
  output logic              ARsuResetTimer,
  output logic              ARsuReady,
  output logic              ARsuError,
  output logic [31:0]       ARsuBootAddr,
  output logic [7:0]        ATest
);

  localparam int unsigned TW = $clog2(CTimeout + 1);

  typedef enum logic [3:0] {
    S_START   = 4'd0,
    S_ISSUE   = 4'd1,
    S_WAIT    = 4'd2,
    S_CAPTURE = 4'd3,
    S_NEXT    = 4'd4,
    S_READY   = 4'd5,
    S_HOST    = 4'd6,
    S_ERROR   = 4'd7
  } state_t;

  state_t            state, nxt;
  logic [2:0]        k;
  logic              retry;
  logic [TW-1:0]     wcnt;
  logic              rdy, err, armed, reconfig, op_wr;
  logic [1:0]        src_q;
  logic [2:0]        param_q;
  logic [CDataW-1:0] data_in_q, data_cap_q;
  logic [CDataW-1:0] shadow [CBootCnt];
  logic [31:0]       boot_q, boot_calc;
  logic [1:0]        mode;

  logic [15:0] off;
  logic        io_wr, io_rd, wr_b, wr_d, rd_b, rd_d;
  logic        ctrl_wr, oper_wr, addr_wr, data_wr, key_wr, wr_ok, rd_ok;
  logic [63:0] rd_data;
  logic        busy_bit;
  logic        unused_mosi;

  assign off         = AIoAddr - CAddrBase;
  assign busy_bit    = (state != S_READY);
  assign mode        = shadow[0][1:0];
  assign unused_mosi = ^AIoMosi;

  if (CBootCnt > 1) begin : g_boot
    assign boot_calc = 32'(shadow[1] >> 2);
  end else begin : g_noboot
    assign boot_calc = '0;
  end

  // Byte accesses use the low mosi/miso lane; a size of 1 is byte, 4 is dword.
  always_comb begin
    io_wr   = (AIoWrSize != '0);
    io_rd   = (AIoRdSize != '0);
    wr_b    = (AIoWrSize == 4'd1);
    wr_d    = (AIoWrSize == 4'd4);
    rd_b    = (AIoRdSize == 4'd1);
    rd_d    = (AIoRdSize == 4'd4);
    ctrl_wr = wr_b && (off == 16'd0);
    oper_wr = wr_b && (off == 16'd1);
    addr_wr = wr_b && (off == 16'd2);
    data_wr = wr_d && (off == 16'd2);
    key_wr  = wr_b && (off == 16'd4);
    wr_ok   = ctrl_wr || oper_wr || addr_wr || data_wr || key_wr;
    rd_ok   = 1'b0;
    rd_data = '0;
    if (rd_b && off == 16'd1) begin
      rd_ok   = 1'b1;
      rd_data = 64'({err, rdy, busy_bit});
    end
    if (rd_b && off == 16'd2) begin
      rd_ok   = 1'b1;
      rd_data = 64'({2'b00, src_q, 1'b0, param_q});
    end
    if (rd_d && off == 16'd2) begin
      rd_ok   = 1'b1;
      rd_data = 64'(data_cap_q);
    end
    for (int unsigned i = 0; i < CBootCnt; i++) begin
      if (rd_d && off == 16'(8 + 4 * i)) begin
        rd_ok   = 1'b1;
        rd_data = 64'(shadow[i]);
      end
    end
  end

  assign AIoMiso    = rd_data;
  assign AIoAddrErr = (io_wr && !wr_ok) || (io_rd && !rd_ok);
  assign AIoAddrAck = (io_wr || io_rd) && !AIoAddrErr;
  assign AIoBusy    = 1'b0;

  always_comb begin
    nxt = state;
    case (state)
      S_START:   nxt = S_ISSUE;
      S_ISSUE:   nxt = S_WAIT;
      S_WAIT: begin
        if (wcnt >= TW'(CTimeout))
          nxt = retry ? S_ERROR : (rdy ? S_HOST : S_ISSUE);
        else if (wcnt != '0 && !ARsuBusy)
          nxt = S_CAPTURE;
      end
      S_CAPTURE: nxt = rdy ? S_READY : S_NEXT;
      S_NEXT:    nxt = (k + 3'd1 == 3'(CBootCnt)) ? S_READY : S_ISSUE;
      S_READY:   if (oper_wr && AIoMosi[1:0] != 2'b00) nxt = S_HOST;
      S_HOST:    nxt = S_WAIT;
      S_ERROR:   nxt = S_ERROR;
      default:   nxt = S_START;
    endcase
  end

  // Host operations are exactly those issued once rdy is set, so rdy selects the
  // Wait/Capture context and the parameter source without a separate mode flag.
  always_comb begin
    ARsuSrc   = '0;
    ARsuParam = '0;
    if (rdy) begin
      ARsuSrc   = src_q;
      ARsuParam = param_q;
    end else begin
      case (k)
        3'd1: begin
          ARsuSrc   = (mode == 2'b00) ? 2'd0 : 2'd2;
          ARsuParam = 3'd4;
        end
        3'd2:    ARsuParam = 3'd1;
        3'd3:    ARsuParam = 3'd2;
        default: ARsuParam = 3'd0;
      endcase
    end
  end

  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH) begin
      state      <= S_START;
      k          <= '0;
      retry      <= 1'b0;
      wcnt       <= '0;
      rdy        <= 1'b0;
      err        <= 1'b0;
      armed      <= 1'b0;
      reconfig   <= 1'b0;
      op_wr      <= 1'b0;
      src_q      <= '0;
      param_q    <= '0;
      data_in_q  <= '0;
      data_cap_q <= '0;
      boot_q     <= '0;
      for (int unsigned i = 0; i < CBootCnt; i++) shadow[i] <= '0;
    end else if (AClkHEn) begin
      state <= nxt;
      if (io_wr) armed <= key_wr && (AIoMosi[7:0] == 8'hA5);
      if (ctrl_wr && AIoMosi[0] && armed && state == S_READY) reconfig <= 1'b1;
      if (addr_wr) begin
        src_q   <= AIoMosi[5:4];
        param_q <= AIoMosi[2:0];
      end
      if (data_wr) data_in_q <= AIoMosi[CDataW-1:0];
      case (state)
        S_START: begin
          k     <= '0;
          retry <= 1'b0;
        end
        S_ISSUE, S_HOST: wcnt <= '0;
        S_WAIT: begin
          wcnt <= wcnt + TW'(1);
          if (nxt == S_ISSUE || nxt == S_HOST) retry <= 1'b1;
          if (nxt == S_ERROR) begin
            err    <= 1'b1;
            rdy    <= 1'b1;
            boot_q <= '0;
          end
        end
        S_CAPTURE: begin
          retry <= 1'b0;
          if (rdy) data_cap_q <= ARsuDataOut;
          else begin
            for (int unsigned i = 0; i < CBootCnt; i++)
              if (k == 3'(i)) shadow[i] <= ARsuDataOut;
          end
        end
        S_NEXT: begin
          k <= k + 3'd1;
          if (nxt == S_READY) begin
            rdy    <= 1'b1;
            boot_q <= boot_calc;
          end
        end
        S_READY: begin
          if (nxt == S_HOST) begin
            op_wr <= AIoMosi[1];
            retry <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes are qualified by the enable so a stalled clock never stretches them.
  assign ARsuReadParam  = AClkHEn && ((state == S_ISSUE) || (state == S_HOST && !op_wr));
  assign ARsuWriteParam = AClkHEn && (state == S_HOST) && op_wr;
  assign ARsuDataIn     = data_in_q;
  assign ARsuReconfig   = reconfig;
  assign ARsuReady      = rdy;
  assign ARsuError      = err;
  assign ARsuBootAddr   = boot_q;
  assign ATest          = {ARsuReadParam, ARsuBusy, err, rdy, state};

`ifdef RSU_WDT_KICK_EN
  localparam int unsigned WW = CWdtBit + 1;
  logic [WW-1:0] wdt;

  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH)      wdt <= '0;
    else if (AClkHEn) wdt <= wdt + WW'(1);
  end

  assign ARsuResetTimer = wdt[CWdtBit];
`else
  assign ARsuResetTimer = 1'b0;
`endif

endmodule
